// File: rtl/s3_retention_ctrl.sv
// S3 retention controller: registered ALU, ring of context slots and a
// staged power sequencer. Optional parity: define S3_CTX_PARITY_EN.
// Ports: clk, reset (sync, high); a, b, opcode, valid, ready (ALU accept);
// s3_req, wake (power requests); result, result_valid, ram_data_out,
// ctx_count, state (status); clk_gate, pg_down, reset_assert,
// iso_clampn_deassert (power controls); ctx_err (parity build only).
module s3_retention_ctrl #(
  parameter int DATA_W   = 4,
  parameter int DEPTH    = 4,
  parameter int IDLE_CYC = 8,
  parameter int STEP_CYC = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        a,
  input  logic [DATA_W-1:0]        b,
  input  logic [1:0]               opcode,
  input  logic                     valid,
  output logic                     ready,
  input  logic                     s3_req,
  input  logic                     wake,
  output logic [DATA_W-1:0]        result,
  output logic                     result_valid,
  output logic [DATA_W-1:0]        ram_data_out,
  output logic [$clog2(DEPTH):0]   ctx_count,
  output logic [2:0]               state,
`ifdef S3_CTX_PARITY_EN
  output logic                     ctx_err,
`endif
  output logic                     clk_gate,
  output logic                     pg_down,
  output logic                     reset_assert,
  output logic                     iso_clampn_deassert
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = $clog2(IDLE_CYC + 1);
  localparam int SW = $clog2(STEP_CYC + 1);
  localparam int DW = 3 * DATA_W + 2;
`ifdef S3_CTX_PARITY_EN
  localparam int MW = DW + 1;
`else
  localparam int MW = DW;
`endif

  typedef enum logic [2:0] {
    S_RUN, S_SAVE, S_GATE, S_PDOWN,
    S_SLEEP, S_PUP, S_RESTORE
  } state_t;

  state_t st, nxt;
  logic [IW-1:0] idle_cnt;
  logic [SW-1:0] step_cnt;
  logic [PW-1:0] wr_ptr;
  logic          wake_pend;
  logic [DATA_W-1:0] ctx_a, ctx_b, alu;
  logic [1:0]        ctx_op;
  logic [MW-1:0] mem [DEPTH];
  logic [MW-1:0] wr_word, rd_word;
  logic [DW-1:0] ctx_word;
  logic accept, step_done;
  logic cg_d, pg_d, ra_d, iso_d;

  assign ready  = (st == S_RUN);
  assign state  = st;
  assign accept = valid && ready;
  assign ctx_word = {ctx_a, ctx_b, ctx_op, result};
`ifdef S3_CTX_PARITY_EN
  assign wr_word = {ctx_word, ^ctx_word};
`else
  assign wr_word = ctx_word;
`endif
  assign rd_word = mem[wr_ptr - PW'(1)];
  assign step_done = (step_cnt == SW'(STEP_CYC - 1));

  always_comb begin
    alu = '0;
    unique case (opcode)
      2'b00: alu = a + b;
      2'b01: alu = a - b;
      2'b10: alu = a & b;
      2'b11: alu = a | b;
      default: alu = '0;
    endcase
  end

  always_comb begin
    nxt = st;
    unique case (st)
      S_RUN:
        if (s3_req && !valid && idle_cnt == IW'(IDLE_CYC))
          nxt = S_SAVE;
      S_SAVE:    nxt = S_GATE;
      S_GATE:    if (step_done) nxt = S_PDOWN;
      S_PDOWN:   if (step_done) nxt = S_SLEEP;
      S_SLEEP:   if (wake || wake_pend) nxt = S_PUP;
      S_PUP:     if (step_done) nxt = S_RESTORE;
      S_RESTORE: nxt = S_RUN;
      default:   nxt = S_RUN;
    endcase
  end

  // Controls are decoded from the state being entered so they
  // change on the same edge as the state.
  always_comb begin
    cg_d  = 1'b0;
    pg_d  = 1'b0;
    ra_d  = 1'b0;
    iso_d = 1'b1;
    unique case (nxt)
      S_GATE: begin
        cg_d = 1'b1; iso_d = 1'b0;
      end
      S_PDOWN, S_SLEEP: begin
        cg_d = 1'b1; iso_d = 1'b0;
        pg_d = 1'b1; ra_d  = 1'b1;
      end
      S_PUP: begin
        cg_d = 1'b1; iso_d = 1'b0; ra_d = 1'b1;
      end
      S_RESTORE: iso_d = 1'b0;
      default: ;
    endcase
  end

  // Retention array has no reset; reset clears the pointers only.
  always_ff @(posedge clk) begin
    if (st == S_SAVE) mem[wr_ptr] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st                  <= S_RUN;
      idle_cnt            <= '0;
      step_cnt            <= '0;
      wr_ptr              <= '0;
      wake_pend           <= 1'b0;
      ctx_a               <= '0;
      ctx_b               <= '0;
      ctx_op              <= '0;
      result              <= '0;
      result_valid        <= 1'b0;
      ram_data_out        <= '0;
      ctx_count           <= '0;
      clk_gate            <= 1'b0;
      pg_down             <= 1'b0;
      reset_assert        <= 1'b0;
      iso_clampn_deassert <= 1'b1;
`ifdef S3_CTX_PARITY_EN
      ctx_err             <= 1'b0;
`endif
    end else begin
      st                  <= nxt;
      result_valid        <= accept;
      clk_gate            <= cg_d;
      pg_down             <= pg_d;
      reset_assert        <= ra_d;
      iso_clampn_deassert <= iso_d;
      step_cnt <= (nxt != st) ? '0 : step_cnt + SW'(1);

      if (accept || st != S_RUN || nxt != S_RUN)
        idle_cnt <= '0;
      else if (idle_cnt != IW'(IDLE_CYC))
        idle_cnt <= idle_cnt + IW'(1);

      if (nxt == S_PUP && st != S_PUP)
        wake_pend <= 1'b0;
      else if (wake && (st == S_SAVE || st == S_GATE ||
                        st == S_PDOWN))
        wake_pend <= 1'b1;

      if (accept) begin
        result <= alu;
        ctx_a  <= a;
        ctx_b  <= b;
        ctx_op <= opcode;
      end

      if (st == S_SAVE) begin
        wr_ptr       <= wr_ptr + PW'(1);
        ram_data_out <= result;
        if (ctx_count != CW'(DEPTH))
          ctx_count <= ctx_count + CW'(1);
      end

      if (st == S_RESTORE) begin
`ifdef S3_CTX_PARITY_EN
        if (^rd_word) begin
          {ctx_a, ctx_b, ctx_op, result} <= '0;
          ram_data_out <= '0;
          ctx_err      <= 1'b1;
        end else begin
          {ctx_a, ctx_b, ctx_op, result} <= rd_word[MW-1:1];
          ram_data_out <= rd_word[DATA_W:1];
        end
`else
        {ctx_a, ctx_b, ctx_op, result} <= rd_word;
        ram_data_out <= rd_word[DATA_W-1:0];
`endif
      end
    end
  end

endmodule
